orient_hist_peak: RTL

//  Consumes the 5-bit direction-bin codes produced by the direction lookup ROMs (32 bins,

---
 rtl/orient_hist_peak.sv | 109 ++++++++++
 1 files changed

// File: rtl/orient_hist_peak.sv
// orient_hist_peak: weighted 32-bin orientation histogram with dominant and secondary peak scan
module orient_hist_peak #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_bin,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_bin,
  output logic [ACC_W-1:0] out_peak,
  output logic [4:0]       out_bin2,
  output logic             out_bin2_v
);
  localparam int SW = (ACC_W > MAG_W ? ACC_W : MAG_W) + 1;
  typedef enum logic [1:0] {ACC, SCAN1, SCAN2, DONE} state_t;
  state_t           r_state;
  logic [ACC_W-1:0] r_hist [32];
  logic [4:0]       r_idx, r_mbin, r_pbin;
  logic [ACC_W-1:0] r_max, r_peak;
  logic             r_have, r_in_ready;
  logic [ACC_W-1:0] w_cur, w_sat, w_val, w_max1, w_max2, w_thresh;
  logic [SW-1:0]    w_sum;
  logic [4:0]       w_bin1, w_bin2;
  logic             w_upd1, w_upd2;
  assign in_ready = r_in_ready;
  assign w_cur    = r_hist[in_bin];
  assign w_sum    = SW'(w_cur) + SW'(in_mag);
  assign w_sat    = (w_sum > SW'({ACC_W{1'b1}})) ? '1 : w_sum[ACC_W-1:0];
  assign w_val    = r_hist[r_idx];
  assign w_upd1   = w_val > r_max;
  assign w_max1   = w_upd1 ? w_val : r_max;
  assign w_bin1   = w_upd1 ? r_idx : r_mbin;
  // the first non-peak bin seeds the secondary search so an all-zero histogram still names a bin
  assign w_upd2   = (r_idx != r_pbin) && (!r_have || w_val > r_max);
  assign w_max2   = w_upd2 ? w_val : r_max;
  assign w_bin2   = w_upd2 ? r_idx : r_mbin;
  assign w_thresh = (r_peak >> 1) + (r_peak >> 2) + (r_peak >> 4);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACC;
      for (int i = 0; i < 32; i++) r_hist[i] <= '0;
      r_in_ready <= 1'b1;
      out_valid  <= 1'b0;
      out_bin    <= '0;
      out_peak   <= '0;
      out_bin2   <= '0;
      out_bin2_v <= 1'b0;
      r_idx      <= '0;
      r_mbin     <= '0;
      r_pbin     <= '0;
      r_max      <= '0;
      r_peak     <= '0;
      r_have     <= 1'b0;
    end else begin
      case (r_state)
        ACC: if (in_valid && r_in_ready) begin
          r_hist[in_bin] <= w_sat;
          if (in_last) begin
            r_state    <= SCAN1;
            r_in_ready <= 1'b0;
            r_idx      <= '0;
            r_max      <= '0;
            r_mbin     <= '0;
          end
        end
        SCAN1: begin
          r_idx  <= r_idx + 5'd1;
          r_max  <= w_max1;
          r_mbin <= w_bin1;
          if (r_idx == 5'd31) begin
            r_peak  <= w_max1;
            r_pbin  <= w_bin1;
            r_max   <= '0;
            r_mbin  <= '0;
            r_have  <= 1'b0;
            r_state <= SCAN2;
          end
        end
        SCAN2: begin
          r_idx  <= r_idx + 5'd1;
          r_max  <= w_max2;
          r_mbin <= w_bin2;
          r_have <= r_have | w_upd2;
          if (r_idx == 5'd31) begin
            out_bin    <= r_pbin;
            out_peak   <= r_peak;
            out_bin2   <= w_bin2;
            out_bin2_v <= (w_max2 >= w_thresh) && (w_max2 != '0);
            out_valid  <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: if (out_ready) begin
          for (int i = 0; i < 32; i++) r_hist[i] <= '0;
          out_valid  <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ACC;
        end
        default: r_state <= ACC;
      endcase
    end
  end
endmodule
